sodor5_instr_sequencer: RTL and testbench

//  Synthesizable constrained-random instruction source for the sodor5 co-simulation rig.

---
 rtl/sodor5_seq_pkg.sv | 40 ++++
 rtl/sodor5_lfsr32.sv | 28 ++
 rtl/sodor5_instr_sequencer.sv | 151 +++++++++++++++
 tb/tb_sodor5_instr_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sodor5_seq_pkg.sv
// Shared types, constants and helpers for the sodor5 instruction sequencer.
// Contents: state enum, RISC-V opcode/NOP constants, LFSR polynomial,
// the LFSR step function and the lfsr-to-instruction encoder.
package sodor5_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRELUDE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [6:0]  OPC_OPIMM = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;  // x^32+x^22+x^2+x+1

    // Galois right-shift step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
    endfunction

    // Turn an LFSR value into a legal OP-IMM or LOAD (LB/LBU) word.
    function automatic logic [31:0] encode_insn(input logic [31:0] l);
        logic [11:0] imm;
        imm = l[31:20];
        if (l[6]) begin
            // Shift-immediates only allow shamt plus the SRA select bit.
            case (l[14:12])
                3'd1:    imm = imm & 12'h01F;
                3'd5:    imm = imm & 12'h41F;
                default: imm = l[31:20];
            endcase
            return {imm, l[19:15], l[14:12], l[11:7], OPC_OPIMM};
        end
        return {l[31:20], l[19:15], (l[14] ? 3'b100 : 3'b000), l[11:7], OPC_LOAD};
    endfunction

endpackage

// File: rtl/sodor5_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and accept-gated advance.
// Latency: q updates one cycle after load/advance.
// Backpressure: holds its value whenever advance is low.
// Ports: clk, reset_n (async, active low), load/load_val, advance, q.
module sodor5_lfsr32
    import sodor5_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        advance,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (advance) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/sodor5_instr_sequencer.sv
// Constrained-random imem response source: NOP prelude, random OP-IMM/LOAD words, NOP drain.
// Latency: first word valid the cycle after start; consecutive words back to back, no bubbles.
// Backpressure: resp_data/resp_valid held while resp_ready is low; LFSR advances only on accept.
// Ports: clk, reset_n, start, resp_ready -> resp_valid, resp_data, busy, done, issued_count.
module sodor5_instr_sequencer
    import sodor5_seq_pkg::*;
#(
    parameter logic [31:0] SEED         = 32'h0000_034D,
    parameter int          NUM_INSTRS   = 64,
    parameter int          NOP_CYCLES   = 3,
    parameter int          DRAIN_CYCLES = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        resp_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] issued_count
);

    // An all-zero seed would lock the LFSR.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    localparam int MAX_AB = (NUM_INSTRS > NOP_CYCLES) ? NUM_INSTRS : NOP_CYCLES;
    localparam int MAX_C  = (MAX_AB > DRAIN_CYCLES) ? MAX_AB : DRAIN_CYCLES;
    localparam int CW     = (MAX_C < 1) ? 1 : $clog2(MAX_C + 1);

    localparam logic [CW-1:0] NOP_LAST   = CW'((NOP_CYCLES   > 0) ? NOP_CYCLES   - 1 : 0);
    localparam logic [CW-1:0] RUN_LAST   = CW'((NUM_INSTRS   > 0) ? NUM_INSTRS   - 1 : 0);
    localparam logic [CW-1:0] DRAIN_LAST = CW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    seq_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lfsr_load, lfsr_adv, issue_inc, issue_clr;
    logic [31:0]   lfsr_q, lfsr_d;
    logic          accept;

    assign accept = resp_valid & resp_ready;

    sodor5_lfsr32 #(.RESET_VAL(SEED_EFF)) u_lfsr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (lfsr_load),
        .load_val (SEED_EFF),
        .advance  (lfsr_adv),
        .q        (lfsr_q)
    );

    // Value the LFSR will hold next cycle; the registered RUN word is built from it
    // so the new word appears together with the new state.
    always_comb begin
        lfsr_d = lfsr_q;
        if (lfsr_load) begin
            lfsr_d = SEED_EFF;
        end else if (lfsr_adv) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        issue_inc = 1'b0;
        issue_clr = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    issue_clr = 1'b1;
                    cnt_d     = '0;
                    state_d   = (NOP_CYCLES == 0) ? ST_RUN : ST_PRELUDE;
                end
            end
            ST_PRELUDE: begin
                if (accept) begin
                    if (cnt_q == NOP_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    lfsr_adv  = 1'b1;
                    issue_inc = 1'b1;
                    if (cnt_q == RUN_LAST) begin
                        cnt_d   = '0;
                        state_d = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // start is not looked at here, so a start coinciding with the
                // final drain accept is dropped.
                if (accept) begin
                    if (cnt_q == DRAIN_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs, all derived from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid   <= 1'b0;
            resp_data    <= NOP_INSN;
            busy         <= 1'b0;
            done         <= 1'b0;
            issued_count <= 16'h0;
        end else begin
            resp_valid <= (state_d == ST_PRELUDE) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
            busy       <= (state_d == ST_PRELUDE) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
            done       <= (state_d == ST_DONE);
            resp_data  <= (state_d == ST_RUN) ? encode_insn(lfsr_d) : NOP_INSN;
            if (issue_clr) begin
                issued_count <= 16'h0;
            end else if (issue_inc && (issued_count != 16'hFFFF)) begin
                issued_count <= issued_count + 16'h1;
            end
        end
    end

endmodule

// File: tb/tb_sodor5_instr_sequencer.sv
module tb_sodor5_instr_sequencer;

    localparam logic [31:0] T_SEED = 32'h0000_034D;
    localparam logic [31:0] T_NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, start0 = 1'b0;
    logic        resp_ready = 1'b0, ready0 = 1'b0;
    logic        resp_valid, valid0;
    logic [31:0] resp_data, data0;
    logic        busy, busy0, done, done0;
    logic [15:0] issued_count, issued0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sodor5_instr_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .resp_ready(resp_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy), .done(done),
        .issued_count(issued_count)
    );

    sodor5_instr_sequencer #(.NUM_INSTRS(4), .NOP_CYCLES(0), .DRAIN_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .resp_ready(ready0),
        .resp_valid(valid0), .resp_data(data0), .busy(busy0), .done(done0),
        .issued_count(issued0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decode LFSR fields arithmetically and assemble the word.
    function automatic bit [31:0] model_word(input bit [31:0] l);
        bit [31:0] imm, rs1, f3, rd;
        imm = l >> 20;
        rs1 = (l >> 15) % 32;
        f3  = (l >> 12) % 8;
        rd  = (l >> 7) % 32;
        if (((l >> 6) % 2) == 1) begin
            if (f3 == 1) imm = imm % 32;
            else if (f3 == 5) imm = (imm % 32) + ((imm / 1024) % 2) * 1024;
            return imm * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * 128 + 19;
        end
        f3 = ((l >> 14) % 2) * 4;
        return imm * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * 128 + 3;
    endfunction

    task automatic build_stream(input int nop, input int n, input int drain,
                                output bit [31:0] q[$]);
        bit [31:0] l;
        q = {};
        l = T_SEED;
        for (int i = 0; i < nop; i++) q.push_back(T_NOP);
        for (int i = 0; i < n; i++) begin
            q.push_back(model_word(l));
            l = (l % 2 == 1) ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
        end
        for (int i = 0; i < drain; i++) q.push_back(T_NOP);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full run with random backpressure, checked against the model stream.
    task automatic do_run(input int pct, input bit poke_start, input bit start_on_last);
        bit [31:0]   exp_q[$];
        logic [31:0] prev;
        bit          hold;
        int          idx, cyc, total, nrun;
        logic [31:0] d;
        build_stream(3, 64, 5, exp_q);
        total = exp_q.size();
        idx = 0; cyc = 0; hold = 0; prev = '0;
        pulse_start();
        while (idx < total && cyc < 3000) begin
            chk("valid_in_run", {31'b0, resp_valid}, 32'd1);
            chk("busy_in_run", {31'b0, busy}, 32'd1);
            if (hold) chk("hold_stable", resp_data, prev);
            resp_ready = ($urandom_range(0, 99) < pct);
            start = (poke_start && idx >= 10 && idx < 14);
            if (start_on_last && idx == total - 1 && resp_ready) start = 1'b1;
            if (resp_ready) begin
                d = resp_data;
                chk("word", d, exp_q[idx]);
                nrun = (idx < 3) ? 0 : ((idx > 67) ? 64 : idx - 3);
                chk("issued_progress", {16'b0, issued_count}, nrun);
                if (idx >= 3 && idx < 67) begin
                    if (d[6:0] == 7'h13 && d[14:12] == 3'd1)
                        chk("slli_funct7", {25'b0, d[31:25]}, 32'h0);
                    else if (d[6:0] == 7'h13 && d[14:12] == 3'd5)
                        chk("srxi_funct7", {31'b0, (d[31:25] == 7'h00 || d[31:25] == 7'h20)}, 32'd1);
                    else if (d[6:0] == 7'h03)
                        chk("load_f3", {31'b0, (d[14:12] == 3'd0 || d[14:12] == 3'd4)}, 32'd1);
                    else if (d[6:0] != 7'h13)
                        chk("opcode", {25'b0, d[6:0]}, 32'h13);
                end
                idx++;
            end
            hold = !resp_ready;
            prev = resp_data;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        resp_ready = 1'b0;
        chk("run_completed_in_budget", {31'b0, (cyc < 3000)}, 32'd1);
        chk("end_busy", {31'b0, busy}, 32'd0);
        chk("end_done", {31'b0, done}, 32'd1);
        chk("end_valid", {31'b0, resp_valid}, 32'd0);
        chk("end_issued", {16'b0, issued_count}, 32'd64);
    endtask

    typedef struct {
        bit          rdy;
        logic [31:0] d;
        bit          v;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[9];

    initial begin
        bit [31:0] q0[$];
        int        acc;
        int        cyc;

        tbl[0] = '{1'b1, T_NOP, 1'b1, 16'd0};
        tbl[1] = '{1'b1, T_NOP, 1'b1, 16'd0};
        tbl[2] = '{1'b1, T_NOP, 1'b1, 16'd0};
        tbl[3] = '{1'b0, 32'h0000_0313, 1'b1, 16'd0};
        tbl[4] = '{1'b0, 32'h0000_0313, 1'b1, 16'd0};
        tbl[5] = '{1'b0, 32'h0000_0313, 1'b1, 16'd0};
        tbl[6] = '{1'b0, 32'h0000_0313, 1'b1, 16'd0};
        tbl[7] = '{1'b1, 32'h0000_0313, 1'b1, 16'd0};
        tbl[8] = '{1'b0, 32'h8020_0183, 1'b1, 16'd1};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_data", resp_data, T_NOP);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_issued", {16'b0, issued_count}, 32'd0);
        reset_n = 1'b1;

        // Prelude, first RUN words and a 4-cycle stall
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            chk("tbl_valid", {31'b0, resp_valid}, {31'b0, tbl[i].v});
            chk("tbl_data", resp_data, tbl[i].d);
            chk("tbl_issued", {16'b0, issued_count}, {16'b0, tbl[i].cnt});
            resp_ready = tbl[i].rdy;
            @(negedge clk);
        end
        chk("tbl_hold_data", resp_data, 32'h8020_0183);

        // Fresh start from reset, then randomized full runs
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        do_run(100, 1'b0, 1'b0);
        do_run(60, 1'b1, 1'b1);   // start poked mid-run and on the final drain accept
        @(negedge clk);
        chk("start_on_last_ignored", {31'b0, busy}, 32'd0);
        do_run(80, 1'b0, 1'b0);   // reproducible second stream from DONE

        // Reset at RUN accept #20
        pulse_start();
        resp_ready = 1'b1;
        acc = 0; cyc = 0;
        while (acc < 23 && cyc < 200) begin
            if (resp_valid) acc++;
            if (acc < 23) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("reach_accept20", {31'b0, (cyc < 200)}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, resp_valid}, 32'd0);
        chk("midrst_issued", {16'b0, issued_count}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        resp_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        do_run(70, 1'b0, 1'b0);

        // No-prelude, no-drain build: first word after start is the first RUN word
        build_stream(0, 4, 0, q0);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        ready0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("nop0_valid", {31'b0, valid0}, 32'd1);
            chk("nop0_word", data0, q0[i]);
            @(negedge clk);
        end
        ready0 = 1'b0;
        chk("nop0_first_is_313", q0[0], 32'h0000_0313);
        chk("nop0_done", {31'b0, done0}, 32'd1);
        chk("nop0_busy", {31'b0, busy0}, 32'd0);
        chk("nop0_issued", {16'b0, issued0}, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
